// File: rtl/decode_if.sv
// Handshake and decoded-bundle signals between fetch, decode_stage and the ID/EX register.
// The master drives the instruction and out_ready. The slave is decode_stage.
interface decode_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       opcode;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shiftam;
  logic [5:0]       funct;
  logic [15:0]      constant;
  logic [XLEN-1:0]  imm_ext;
  logic [25:0]      jtarget;
  logic [1:0]       itype;
  logic [4:0]       dest_reg;
  logic             reg_write;
  logic             is_load;
  logic             is_store;
  logic             is_branch;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, instruction, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, rd, shiftam, funct, constant,
           imm_ext, jtarget, itype, dest_reg, reg_write, is_load, is_store,
           is_branch, stall_cnt
  );

  modport slave (
    input  in_valid, instruction, out_ready,
    output in_ready, out_valid, opcode, rs, rt, rd, shiftam, funct, constant,
           imm_ext, jtarget, itype, dest_reg, reg_write, is_load, is_store,
           is_branch, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Registered MIPS-I decode stage: field split, classification, immediate extension.
// Define LOAD_USE_STALL_EN to enable load-use bubble insertion and the stall counter.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);
  typedef enum logic [1:0] {
    IT_R   = 2'd0,
    IT_I   = 2'd1,
    IT_J   = 2'd2,
    IT_ILL = 2'd3
  } itype_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm_ext;
    itype_e          itype;
    logic [4:0]      dest_reg;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
  } bundle_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  bundle_t    dec;
  bundle_t    held;
  logic       held_valid;
  logic       hazard;
  logic       accept;
  logic [5:0] op_in;

  assign op_in = bus.instruction[31:26];

  always_comb begin
    // NOTE: the whole bundle gets a default first so no case arm can leave a field unassigned and infer a latch.
    dec           = '0;
    dec.instr     = bus.instruction;
    dec.imm_ext   = XLEN'($signed(bus.instruction[15:0]));
    dec.itype     = IT_ILL;
    case (op_in)
      OP_RTYPE: begin
        dec.itype    = IT_R;
        dec.dest_reg = bus.instruction[15:11];
      end
      OP_J: begin
        dec.itype     = IT_J;
        dec.is_branch = 1'b1;
      end
      OP_JAL: begin
        dec.itype     = IT_J;
        dec.is_branch = 1'b1;
        dec.dest_reg  = 5'd31;
      end
      OP_BEQ, OP_BNE: begin
        dec.itype     = IT_I;
        dec.is_branch = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_LUI: begin
        dec.itype    = IT_I;
        dec.dest_reg = bus.instruction[20:16];
      end
      // Logical immediates take the constant unsigned.
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.itype    = IT_I;
        dec.dest_reg = bus.instruction[20:16];
        dec.imm_ext  = XLEN'(bus.instruction[15:0]);
      end
      OP_LW: begin
        dec.itype    = IT_I;
        dec.dest_reg = bus.instruction[20:16];
        dec.is_load  = 1'b1;
      end
      OP_SW: begin
        dec.itype    = IT_I;
        dec.is_store = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef LOAD_USE_STALL_EN
  logic             reads_rs;
  logic             reads_rt;
  logic [4:0]       held_rt;
  logic [CNT_W-1:0] stall_q;

  always_comb begin
    reads_rs = (dec.itype == IT_R) || ((dec.itype == IT_I) && (op_in != OP_LUI));
    reads_rt = (dec.itype == IT_R) || (op_in == OP_BEQ) || (op_in == OP_BNE) || (op_in == OP_SW);
  end

  assign held_rt = held.instr[20:16];
  assign hazard  = bus.in_valid & held_valid & held.is_load & (held.dest_reg != 5'd0) &
                   ((reads_rs & (bus.instruction[25:21] == held_rt)) |
                    (reads_rt & (bus.instruction[20:16] == held_rt)));

  // One count per bubble: the cycle the load drains while the dependent waits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (hazard && bus.out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign hazard        = 1'b0;
  assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

  assign bus.in_ready = (!held_valid | bus.out_ready) & !hazard;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    // NOTE: the held bundle is reset along with the valid bit so every output reads 0 after reset, not just out_valid.
    if (!rst) begin
      held       <= '0;
      held_valid <= 1'b0;
    end else if (accept) begin
      held       <= dec;
      held_valid <= 1'b1;
    end else if (bus.out_ready) begin
      held_valid <= 1'b0;
    end
  end

  assign bus.out_valid = held_valid;
  assign bus.opcode    = held.instr[31:26];
  assign bus.rs        = held.instr[25:21];
  assign bus.rt        = held.instr[20:16];
  assign bus.rd        = held.instr[15:11];
  assign bus.shiftam   = held.instr[10:6];
  assign bus.funct     = held.instr[5:0];
  assign bus.constant  = held.instr[15:0];
  assign bus.jtarget   = held.instr[25:0];
  assign bus.imm_ext   = held.imm_ext;
  assign bus.itype     = held.itype;
  assign bus.dest_reg  = held.dest_reg;
  assign bus.reg_write = (held.dest_reg != 5'd0);
  assign bus.is_load   = held.is_load;
  assign bus.is_store  = held.is_store;
  assign bus.is_branch = held.is_branch;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a scoreboard of expected bundles.
// Bubble and stall_cnt expectations follow LOAD_USE_STALL_EN.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_if #(.XLEN(32), .CNT_W(16)) bus ();
  decode_stage #(.XLEN(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef LOAD_USE_STALL_EN
  localparam int EXP_BUBBLES = 1;
`else
  localparam int EXP_BUBBLES = 0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [1:0]  itype;
    logic [4:0]  dest;
    logic        ld;
    logic        st;
    logic        br;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   idle_cycles = 0;
  bit   acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t       e;
    logic [5:0] op;
    logic [15:0] c;
    op      = w[31:26];
    c       = w[15:0];
    e.instr = w;
    e.ld    = (op == 6'h23);
    e.st    = (op == 6'h2B);
    e.br    = op inside {6'h02, 6'h03, 6'h04, 6'h05};
    if (op == 6'h00) e.itype = 2'd0;
    else if (op inside {6'h02, 6'h03}) e.itype = 2'd2;
    else if (op inside {6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B})
      e.itype = 2'd1;
    else e.itype = 2'd3;
    e.imm = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0000, c} : {{16{c[15]}}, c};
    if (op == 6'h00) e.dest = w[15:11];
    else if (op == 6'h03) e.dest = 5'd31;
    else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23}) e.dest = w[20:16];
    else e.dest = 5'd0;
    return e;
  endfunction

  task automatic check_bundle(input exp_t e);
    check("opcode",    bus.opcode,    e.instr[31:26]);
    check("rs",        bus.rs,        e.instr[25:21]);
    check("rt",        bus.rt,        e.instr[20:16]);
    check("rd",        bus.rd,        e.instr[15:11]);
    check("shiftam",   bus.shiftam,   e.instr[10:6]);
    check("funct",     bus.funct,     e.instr[5:0]);
    check("constant",  bus.constant,  e.instr[15:0]);
    check("jtarget",   bus.jtarget,   e.instr[25:0]);
    check("imm_ext",   bus.imm_ext,   e.imm);
    check("itype",     bus.itype,     e.itype);
    check("dest_reg",  bus.dest_reg,  e.dest);
    check("reg_write", bus.reg_write, e.dest != 5'd0);
    check("is_load",   bus.is_load,   e.ld);
    check("is_store",  bus.is_store,  e.st);
    check("is_branch", bus.is_branch, e.br);
  endtask

  // One clock: sample the handshake mid-cycle, score drains, record accepts.
  task automatic tick(output bit accepted);
    exp_t e;
    accepted = 1'b0;
    #1;
    if (rst) begin
      if (bus.out_valid && bus.out_ready) begin
        check("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_bundle(e);
        end
      end
      if (!bus.out_valid) idle_cycles++;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.instruction));
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    bit a;
    int n;
    n               = 0;
    bus.in_valid    = 1'b1;
    bus.instruction = ins;
    do begin
      tick(a);
      n++;
    end while (!a && n < 8);
    check("accept_in_time", a, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for two edges with a valid instruction presented.
    rst             = 1'b0;
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h02329820;
    bus.out_ready   = 1'b1;
    tick(acc);
    tick(acc);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_stall_cnt", bus.stall_cnt, 16'd0);
    check("rst_dest_reg",  bus.dest_reg,  5'd0);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);

    // R-type add $19,$17,$18.
    send(32'h02329820);
    check("r_latency_valid", bus.out_valid, 1'b1);
    check("r_rs",        bus.rs,        5'd17);
    check("r_rt",        bus.rt,        5'd18);
    check("r_rd",        bus.rd,        5'd19);
    check("r_funct",     bus.funct,     6'h20);
    check("r_itype",     bus.itype,     2'd0);
    check("r_dest_reg",  bus.dest_reg,  5'd19);
    check("r_reg_write", bus.reg_write, 1'b1);

    // I-type: lw, andi (zero-extended), addi with negative constant.
    send(32'h8E320004);
    check("lw_is_load",  bus.is_load,  1'b1);
    check("lw_dest_reg", bus.dest_reg, 5'd18);
    check("lw_imm_ext",  bus.imm_ext,  32'h00000004);
    send(32'h3222FFFF);
    check("andi_imm_ext", bus.imm_ext, 32'h0000FFFF);
    send(32'h2002FFFC);
    check("addi_imm_ext", bus.imm_ext, 32'hFFFFFFFC);

    // J-type and branch.
    send(32'h08000002);
    check("j_itype",     bus.itype,     2'd2);
    check("j_jtarget",   bus.jtarget,   26'd2);
    check("j_is_branch", bus.is_branch, 1'b1);
    check("j_dest_reg",  bus.dest_reg,  5'd0);
    send(32'h12320001);
    check("beq_itype",     bus.itype,     2'd1);
    check("beq_is_branch", bus.is_branch, 1'b1);
    check("beq_imm_ext",   bus.imm_ext,   32'h00000001);
    check("beq_reg_write", bus.reg_write, 1'b0);
    tick(acc);

    // Load-use: lw $18 then an R-type reading $18.
    send(32'h8E320004);
    idle_cycles = 0;
    send(32'h02329820);
    check("lu_bubbles",   idle_cycles,   EXP_BUBBLES);
    check("lu_stall_cnt", bus.stall_cnt, EXP_BUBBLES);
    check("lu_out_valid", bus.out_valid, 1'b1);
    tick(acc);

    // Backpressure: hold an ori for three cycles with an illegal op waiting.
    bus.out_ready = 1'b0;
    send(32'h34A51234);
    bus.in_valid    = 1'b1;
    bus.instruction = 32'hFC000000;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      check("bp_in_ready",  bus.in_ready,  1'b0);
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_sb_depth",  sb.size(),     1);
      if (sb.size() != 0) check_bundle(sb[0]);
    end
    bus.out_ready = 1'b1;
    send(32'hFC000000);
    check("ill_itype",     bus.itype,     2'd3);
    check("ill_reg_write", bus.reg_write, 1'b0);
    check("ill_is_branch", bus.is_branch, 1'b0);
    tick(acc);

    // Reset while a bundle is held under backpressure: nothing is replayed.
    bus.out_ready = 1'b0;
    send(32'h24420001);
    rst = 1'b0;
    tick(acc);
    rst = 1'b1;
    sb.delete();
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_stall_cnt", bus.stall_cnt, 16'd0);
    bus.out_ready = 1'b1;
    tick(acc);
    tick(acc);
    check("midrst_no_replay", bus.out_valid, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered MIPS-I instruction decode stage with a valid/ready handshake on both sides, sitting between fetch and the ID/EX pipeline register.
- Splits each instruction into its fields, classifies it (R/I/J/illegal) and produces a sign- or zero-extended immediate of width XLEN.
- Detects load-use hazards against the instruction it currently holds and inserts exactly one bubble when one is found.

Parameters:
- XLEN, 32, width of the extended immediate; legal when ≥16.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  the instruction input is valid.
- in_ready  out  1  the stage accepts the instruction this cycle.
- instruction  in  32  raw instruction word.
- out_valid  out  1  the decoded bundle is valid.
- out_ready  in  1  downstream accepts the bundle.
- opcode  out  6  instr[31:26].
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- shiftam  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- constant  out  16  instr[15:0].
- imm_ext  out  XLEN  extended immediate.
- jtarget  out  26  instr[25:0].
- itype  out  2  0=R, 1=I, 2=J, 3=illegal.
- dest_reg  out  5  register written by this instruction (0 when none).
- reg_write, is_load, is_store, is_branch  out  1 each  control flags.
- stall_cnt  out  CNT_W  number of bubble cycles inserted.

Behaviour:
- Reset: when rst=0 at a clk edge, all outputs and internal state go to 0 (out_valid=0, stall_cnt=0). Reset in the middle of operation discards the held bundle; nothing is replayed.
- Storage and latency: the stage holds one output register. Latency is 1 cycle from acceptance (in_valid & in_ready) to out_valid.
- in_ready = (!out_valid | out_ready) & !hazard. in_ready must not depend combinationally on in_valid, except through the hazard term.
- Throughput: when downstream drains the held bundle and a new instruction is accepted in the same cycle, the register is replaced. Sustained rate is 1 instruction per cycle.
- When out_valid & !out_ready: all outputs hold stable.
- Classification:
  - opcode 0x00 → R.
  - opcodes 0x02 (j) and 0x03 (jal) → J.
  - opcodes {0x04 beq, 0x05 bne, 0x08 addi, 0x09 addiu, 0x0A slti, 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui, 0x23 lw, 0x2B sw} → I.
  - any other opcode → 3 (illegal). An illegal instruction still passes through, with reg_write=0 and all flags 0.
- imm_ext: zero-extend constant for andi, ori and xori; sign-extend it for all other opcodes.
- dest_reg:
  - R → rd.
  - addi, addiu, slti, andi, ori, xori, lui, lw → rt.
  - jal → 31.
  - otherwise 0.
  - reg_write = (dest_reg != 0).
- Flags: is_load for lw; is_store for sw; is_branch for beq, bne, j and jal.
- Source registers read by the incoming instruction:
  - rs is read by everything except J-type, lui and illegal.
  - rt is read by R-type, beq, bne and sw.
- Hazard: hazard = in_valid & out_valid & held is_load & held dest_reg != 0 & (incoming reads rs == held rt, or incoming reads rt == held rt).
  - While hazard is high, the stage does not accept; the held lw drains normally.
  - In the cycle after the lw drains, out_valid=0 (the bubble), hazard clears, and the dependent instruction is accepted. The result is exactly one bubble per load-use pair.
- stall_cnt increments in each cycle where hazard=1 and out_ready=1 (one count per bubble), and saturates at 2^CNT_W−1.

Optional Feature:
- Macro: LOAD_USE_STALL_EN.
- Defined: hazard logic and stall_cnt behave as described above.
- Undefined: hazard is tied 0, so in_ready = !out_valid | out_ready; stall_cnt is constant 0. Use this build when the downstream forwarding unit resolves load-use hazards itself.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 → out_valid=0, stall_cnt=0, in_ready=1 after rst=1.
- R-type decode: 0x02329820 → opcode 0, rs 17, rt 18, rd 19, funct 0x20, itype 0, dest_reg 19, reg_write 1, one cycle after acceptance.
- I-type decode: 0x8E320004 → is_load 1, dest_reg 18, imm_ext 0x00000004. Then 0x3222FFFF (andi) → imm_ext 0x0000FFFF. Then addi with constant 0xFFFC → imm_ext 0xFFFFFFFC.
- J-type and branch decode: 0x08000002 → itype 2, jtarget 2, is_branch 1, dest_reg 0. Then 0x12320001 → itype 1, is_branch 1, imm_ext 1, reg_write 0.
- Load-use: 0x8E320004 followed by 0x02329820 with out_ready=1 → exactly one out_valid=0 cycle between them, stall_cnt=1. Repeat with LOAD_USE_STALL_EN undefined → no bubble, stall_cnt=0.
- Backpressure: hold out_ready=0 for 3 cycles with a bundle held → outputs stable and in_ready=0. Then opcode 0x3F is accepted → itype 3, reg_write 0.
